cpu_ctrl_fsm: RTL
=================

Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control and decode stage directly upstream of the 8x8 register file.
- Fetches a 32-bit instruction over a request/valid handshake and decodes it.
- Drives the register-file read/write addresses and the WRITE strobe, plus ALU and operand-select controls.
- Sequences every instruction through FETCH, DECODE, EXECUTE and WRITEBACK, and maintains the PC.

Parameters:
- EXEC_CYCLES, 2, number of cycles held in EXECUTE (covers reg-file read delay plus ALU delay); legal range 1..15.
- PC_RESET, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, PC increment per retired or skipped instruction.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  freeze: when high at an edge, all state holds (RESET has priority).
- INSTRUCTION  in  32  instruction word from instruction memory.
- INSTR_VALID  in  1  INSTRUCTION is valid this cycle.
- INSTR_REQ  out  1  fetch request, high throughout FETCH.
- PC  out  32  address of current instruction.
- INADDRESS  out  3  reg-file write address (INSTRUCTION[18:16]).
- OUT1ADDRESS  out  3  reg-file read port 1 address (INSTRUCTION[10:8]).
- OUT2ADDRESS  out  3  reg-file read port 2 address (INSTRUCTION[2:0]).
- WRITE  out  1  reg-file write enable.
- ALUOP  out  3  000 FWD, 001 ADD, 010 AND, 011 OR.
- NEG_SEL  out  1  negate operand 2 (used for sub).
- IMM_SEL  out  1  operand 2 comes from IMM, not OUT2.
- IMM  out  8  INSTRUCTION[7:0].
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.
- BUSY  out  1  high in any state except IDLE.

Behaviour:
- Instruction format: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm.
  - Only the low 3 bits of each register field are used; upper bits are ignored.
- Opcodes:
  - 0x00 loadi: FWD, IMM_SEL=1.
  - 0x01 mov: FWD.
  - 0x02 add: ADD.
  - 0x03 sub: ADD, NEG_SEL=1.
  - 0x04 and: AND.
  - 0x05 or: OR.
  - 0x06..0xFF: illegal.
- Reset values:
  - State IDLE, PC=PC_RESET, all other outputs 0.
  - Decode latches cleared, execute counter 0.
- States and transitions:
  - IDLE -> FETCH on the first edge with RESET=0.
  - FETCH: INSTR_REQ=1.
    - INSTRUCTION is latched on the first edge where INSTR_VALID=1; go to DECODE.
    - Otherwise stay in FETCH indefinitely.
  - DECODE (1 cycle): all address, ALUOP, NEG_SEL, IMM_SEL and IMM outputs come from registered decode latches, valid from DECODE entry.
    - Legal opcode -> EXECUTE with counter loaded to EXEC_CYCLES-1.
    - Illegal opcode -> ILLEGAL=1 for this cycle, PC+=PC_STEP, go to FETCH (no writeback).
  - EXECUTE: counter decrements each edge; -> WRITEBACK when counter=0.
    - With EXEC_CYCLES=1, EXECUTE lasts exactly 1 cycle.
  - WRITEBACK (1 cycle): WRITE=1 for exactly one rising edge, then PC+=PC_STEP and go to FETCH.
- Latency: legal instruction = FETCH wait (>=1) + 1 + EXEC_CYCLES + 1 cycles.
- Decode outputs hold their values from DECODE until the next instruction's DECODE, so they are stable throughout WRITEBACK.
- INSTR_VALID outside FETCH is ignored. INSTR_VALID held high gives back-to-back fetch with no bubble beyond the FETCH cycle.
- STALL:
  - Freezes state, counter, PC and all outputs.
  - A stall in WRITEBACK keeps WRITE high; rewriting the same value is acceptable.
  - A stall in FETCH suppresses capture even if INSTR_VALID=1.
- Reset mid-operation: on the next edge the block returns to IDLE, WRITE=0, PC=PC_RESET, and any in-flight instruction is discarded.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LOADI..OP_OR;
  - ALUOP codes ALU_FWD, ALU_ADD, ALU_AND, ALU_OR;
  - FSM state encoding (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK);
  - instruction field bit positions.
- Sub-module instr_decoder: purely combinational opcode -> {ALUOP, NEG_SEL, IMM_SEL, legal}. It is instantiated once; its outputs are registered in the FSM at the FETCH->DECODE edge.

Test Plan:
- Reset then loadi r3,0x2A (32'h0003_002A), VALID in the first FETCH cycle, EXEC_CYCLES=2:
  - required: INADDRESS=3, IMM_SEL=1, IMM=0x2A, ALUOP=000;
  - WRITE high exactly 1 cycle, 4 cycles after capture;
  - PC 0->4.
- sub r1,r2,r5 (32'h0301_0205):
  - required: OUT1ADDRESS=2, OUT2ADDRESS=5, ALUOP=001, NEG_SEL=1, INADDRESS=1;
  - one WRITE pulse.
- Opcode 0x07: ILLEGAL pulses 1 cycle, WRITE never asserted, PC+=4, back in FETCH the next cycle.
- INSTR_VALID low for 5 cycles in FETCH:
  - required: INSTR_REQ held, state FETCH, PC unchanged;
  - capture on the 6th-cycle VALID.
- STALL for 3 cycles during WRITEBACK: WRITE high for 4 cycles, PC increments only once after STALL drops.
- RESET asserted in EXECUTE of add: next edge gives IDLE, WRITE=0, PC=0, and no WRITE pulse for that add.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the control/decode stage: opcodes, ALU codes, FSM states, field positions.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;
  localparam int REG_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       neg_sel;
    logic       imm_sel;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into ALU controls and a legality flag.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_LOADI: begin dec_o.legal = 1'b1; dec_o.aluop = ALU_FWD; dec_o.imm_sel = 1'b1; end
      OP_MOV:   begin dec_o.legal = 1'b1; dec_o.aluop = ALU_FWD; end
      OP_ADD:   begin dec_o.legal = 1'b1; dec_o.aluop = ALU_ADD; end
      OP_SUB:   begin dec_o.legal = 1'b1; dec_o.aluop = ALU_ADD; dec_o.neg_sel = 1'b1; end
      OP_AND:   begin dec_o.legal = 1'b1; dec_o.aluop = ALU_AND; end
      OP_OR:    begin dec_o.legal = 1'b1; dec_o.aluop = ALU_OR;  end
      default:  dec_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute/writeback sequencer feeding the 8x8 register file and ALU controls.
// Decode fields are latched at capture and held until the next instruction's capture.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter logic [31:0] PC_STEP     = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic        INSTR_REQ,
  output logic [31:0] PC,
  output logic [2:0]  INADDRESS,
  output logic [2:0]  OUT1ADDRESS,
  output logic [2:0]  OUT2ADDRESS,
  output logic        WRITE,
  output logic [2:0]  ALUOP,
  output logic        NEG_SEL,
  output logic        IMM_SEL,
  output logic [7:0]  IMM,
  output logic        ILLEGAL,
  output logic        BUSY
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  dst_q, src1_q, src2_q;
  logic [7:0]  imm_q;
  dec_t        dec_q, dec_w;
  logic        capture;
  logic        unused_fields;

  instr_decoder u_dec (
    .opcode_i (INSTRUCTION[OPC_LSB +: 8]),
    .dec_o    (dec_w)
  );

  assign capture       = (state_q == ST_FETCH) && INSTR_VALID;
  assign unused_fields = ^{INSTRUCTION[DST_LSB+REG_W +: 5], INSTRUCTION[SRC1_LSB+REG_W +: 5]};

  // STALL gates every register; RESET overrides it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= PC_RESET;
      dst_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      imm_q   <= '0;
      dec_q   <= '0;
    end else if (!STALL) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      if (capture) begin
        dst_q  <= INSTRUCTION[DST_LSB  +: REG_W];
        src1_q <= INSTRUCTION[SRC1_LSB +: REG_W];
        src2_q <= INSTRUCTION[SRC2_LSB +: REG_W];
        imm_q  <= INSTRUCTION[SRC2_LSB +: 8];
        dec_q  <= dec_w;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (INSTR_VALID) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_q.legal) begin
          state_d = ST_EXECUTE;
          cnt_d   = EXEC_LOAD;
        end else begin
          state_d = ST_FETCH;
          pc_d    = pc_q + PC_STEP;
        end
      end
      ST_EXECUTE: begin
        if (cnt_q == 4'd0) state_d = ST_WRITEBACK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + PC_STEP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    INSTR_REQ = (state_q == ST_FETCH);
    WRITE     = (state_q == ST_WRITEBACK);
    ILLEGAL   = (state_q == ST_DECODE) && !dec_q.legal;
    BUSY      = (state_q != ST_IDLE);
  end

  assign PC          = pc_q;
  assign INADDRESS   = dst_q;
  assign OUT1ADDRESS = src1_q;
  assign OUT2ADDRESS = src2_q;
  assign ALUOP       = dec_q.aluop;
  assign NEG_SEL     = dec_q.neg_sel;
  assign IMM_SEL     = dec_q.imm_sel;
  assign IMM         = imm_q;

endmodule
